// File: rtl/simt_scheduler_pkg.sv
// Shared types and encodings for the SIMT scheduler: core states, LSU/fetcher codes, PC type.
package simt_pkg;

  localparam int PC_BITS = 8;

  typedef logic [PC_BITS-1:0] pc_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } core_state_t;

  localparam logic [1:0] LSU_IDLE       = 2'b00;
  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;
  localparam logic [1:0] LSU_DONE       = 2'b11;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/simt_scheduler_min_pc_select.sv
// Combinational argmin over T PCs with valid bits; returns the lowest valid PC and every
// slot sitting at it. No valid input yields min 0 and an empty mask.
module min_pc_select #(
  parameter int T = 4,
  parameter int W = 8
) (
  input  logic [W*T-1:0] i_pc,
  input  logic [T-1:0]   i_valid,
  output logic [W-1:0]   o_min_pc,
  output logic [T-1:0]   o_mask
);

  logic [W-1:0] w_min;
  logic         w_found;

  always_comb begin
    w_min   = '0;
    w_found = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (i_valid[i] && (!w_found || (i_pc[W*i +: W] < w_min))) begin
        w_min   = i_pc[W*i +: W];
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    o_mask = '0;
    for (int i = 0; i < T; i++) begin
      o_mask[i] = i_valid[i] && (i_pc[W*i +: W] == w_min);
    end
  end

  assign o_min_pc = w_min;

endmodule

// File: rtl/simt_scheduler.sv
// Per-core SIMT control FSM: per-thread PCs, issues each instruction to the lowest live PC group.
// Optional perf counters (cycle/issue/diverge) when SIMT_PERF_COUNT_EN is defined.
module simt_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = simt_pkg::PC_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]    thread_count,
  input  logic [2:0]                            fetcher_state,
  input  logic                                  decoded_mem_read_enable,
  input  logic                                  decoded_mem_write_enable,
  input  logic                                  decoded_ret,
  input  logic [2*THREADS_PER_BLOCK-1:0]        lsu_state,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0]  next_pc,
  output logic [2:0]                            core_state,
  output logic [PC_BITS-1:0]                    current_pc,
  output logic [THREADS_PER_BLOCK-1:0]          active_mask,
  output logic                                  done
`ifdef SIMT_PERF_COUNT_EN
  ,
  output logic [31:0]                           cycle_count,
  output logic [31:0]                           issue_count,
  output logic [31:0]                           diverge_count
`endif
);
  import simt_pkg::*;

  localparam int T  = THREADS_PER_BLOCK;
  localparam int CW = $clog2(T) + 1;

  core_state_t        r_state, w_state_nxt;
  logic [PC_BITS-1:0] r_pc [T];
  logic [T-1:0]       r_retired;
  logic [T-1:0]       r_active_mask;
  logic [PC_BITS-1:0] r_current_pc;

  logic [CW-1:0]        w_count;
  logic [T-1:0]         w_launch_live;
  logic [T-1:0]         w_upd_retired;
  logic [T-1:0]         w_mem_ready;
  logic [PC_BITS*T-1:0] w_upd_pc;
  logic [PC_BITS-1:0]   w_min_pc;
  logic [T-1:0]         w_min_mask;
  logic                 w_mem_op;

  assign w_count  = (thread_count > CW'(T)) ? CW'(T) : thread_count;
  assign w_mem_op = decoded_mem_read_enable | decoded_mem_write_enable;

  // Post-UPDATE view of every thread; feeds both the register update and the next issue choice.
  always_comb begin
    w_launch_live = '0;
    w_upd_retired = r_retired;
    w_upd_pc      = '0;
    w_mem_ready   = '0;
    for (int i = 0; i < T; i++) begin
      w_launch_live[i]           = (CW'(i) < w_count);
      w_upd_pc[PC_BITS*i +: PC_BITS] = r_pc[i];
      w_mem_ready[i] = !r_active_mask[i] ||
                       (lsu_state[2*i +: 2] == LSU_IDLE) ||
                       (lsu_state[2*i +: 2] == LSU_DONE);
      if (r_active_mask[i]) begin
        if (decoded_ret) w_upd_retired[i] = 1'b1;
        else             w_upd_pc[PC_BITS*i +: PC_BITS] = next_pc[PC_BITS*i +: PC_BITS];
      end
    end
  end

  min_pc_select #(.T(T), .W(PC_BITS)) u_min_pc_select (
    .i_pc     (w_upd_pc),
    .i_valid  (~w_upd_retired),
    .o_min_pc (w_min_pc),
    .o_mask   (w_min_mask)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = (w_count == '0) ? S_DONE : S_FETCH;
      S_FETCH:   if (fetcher_state == FETCHER_FETCHED) w_state_nxt = S_DECODE;
      S_DECODE:  w_state_nxt = S_REQUEST;
      S_REQUEST: w_state_nxt = S_WAIT;
      S_WAIT:    if (!w_mem_op || (&w_mem_ready)) w_state_nxt = S_EXECUTE;
      S_EXECUTE: w_state_nxt = S_UPDATE;
      S_UPDATE:  w_state_nxt = (&w_upd_retired) ? S_DONE : S_FETCH;
      S_DONE:    w_state_nxt = S_DONE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < T; i++) r_pc[i] <= '0;
      r_retired     <= '1;
      r_current_pc  <= '0;
      r_active_mask <= '0;
    end else if (r_state == S_IDLE && start && w_count != '0) begin
      for (int i = 0; i < T; i++) r_pc[i] <= '0;
      r_retired     <= ~w_launch_live;
      r_current_pc  <= '0;
      r_active_mask <= w_launch_live;
    end else if (r_state == S_UPDATE) begin
      for (int i = 0; i < T; i++) r_pc[i] <= w_upd_pc[PC_BITS*i +: PC_BITS];
      r_retired     <= w_upd_retired;
      r_current_pc  <= w_min_pc;
      r_active_mask <= w_min_mask;
    end
  end

  assign core_state  = r_state;
  assign current_pc  = r_current_pc;
  assign active_mask = r_active_mask;
  assign done        = (r_state == S_DONE);

`ifdef SIMT_PERF_COUNT_EN
  logic [31:0] r_cycle_count, r_issue_count, r_diverge_count;
  logic        w_busy;

  assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);

  // Divergence means some still-live thread sat out this instruction.
  always_ff @(posedge clk) begin
    if (reset || (r_state == S_IDLE && start)) begin
      r_cycle_count   <= '0;
      r_issue_count   <= '0;
      r_diverge_count <= '0;
    end else begin
      if (w_busy) r_cycle_count <= sat_inc(r_cycle_count);
      if (r_state == S_UPDATE) begin
        r_issue_count <= sat_inc(r_issue_count);
        if (r_active_mask != ~r_retired) r_diverge_count <= sat_inc(r_diverge_count);
      end
    end
  end

  assign cycle_count   = r_cycle_count;
  assign issue_count   = r_issue_count;
  assign diverge_count = r_diverge_count;
`endif

endmodule
